// File: rtl/reg_bank_reader.sv
// reg_bank_reader: Depth x Size register bank with per-entry write port and a
// single-entry request/response read port with back-pressure.
//
// Optional build macro: REG_BANK_READER_BYPASS_EN
//   defined   -> a read accepted on the same edge as a write to the same
//                in-range entry returns the new write data (forwarding).
//   undefined -> such a read returns the entry value from before the write.
//
// Read handshake: a request is accepted on a rising edge where
// rd_req && rd_ready. rd_ready = !rd_valid || rd_ack. The response appears
// one cycle after acceptance and stays frozen (rd_valid, rd_data, rd_err)
// until a rising edge where rd_ack is high. rd_ack with rd_req in the same
// cycle retires the current response and accepts the next one.
module reg_bank_reader #(
    parameter int Size     = 8,
    parameter int Depth    = 4,
    parameter int AddrBits = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [AddrBits-1:0] wr_addr,
    input  logic [Size-1:0]     wr_data,
    input  logic                wr_en,
    input  logic                rd_req,
    input  logic [AddrBits-1:0] rd_addr,
    output logic                rd_ready,
    output logic                rd_valid,
    output logic [Size-1:0]     rd_data,
    output logic                rd_err,
    input  logic                rd_ack,
    output logic                dbg_state_o
);

    localparam int unsigned DepthU = Depth;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [Size-1:0] mem_q [Depth];
    logic [Size-1:0] mem_d [Depth];
    logic [Size-1:0] rd_data_q, rd_data_d;
    logic            rd_err_q, rd_err_d;

    logic [31:0]     wr_addr_w;
    logic [31:0]     rd_addr_w;
    logic            rd_in_range;
    logic            accept;
    logic [Size-1:0] rd_entry;

    assign wr_addr_w   = 32'(wr_addr);
    assign rd_addr_w   = 32'(rd_addr);
    assign rd_in_range = (rd_addr_w < DepthU);
    assign accept      = rd_req && rd_ready;

    // Write path: only in-range addresses select an entry; others fall through.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < DepthU; i++) begin
            if (wr_en && (wr_addr_w == i)) begin
                mem_d[i] = wr_data;
            end
        end
    end

    // Entry storage, cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DepthU; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read mux over the pre-write entry values; out-of-range reads yield zero.
    always_comb begin
        rd_entry = '0;
        for (int unsigned i = 0; i < DepthU; i++) begin
            if (rd_addr_w == i) begin
                rd_entry = mem_q[i];
            end
        end
    end

    // Response capture values; held registers only update on an accepting edge.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        if (accept) begin
            rd_data_d = rd_in_range ? rd_entry : '0;
            rd_err_d  = !rd_in_range;
`ifdef REG_BANK_READER_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr) && rd_in_range) begin
                rd_data_d = wr_data;
            end
`endif
        end
    end

    // Response payload registers; the response is a snapshot taken at acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM next state: IDLE waits for a request, RESP holds until acked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rd_ack && !rd_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read FSM outputs; rd_ready depends combinationally only on rd_ack.
    always_comb begin
        rd_valid    = (state_q == RESP);
        rd_ready    = (state_q != RESP) || rd_ack;
        rd_data     = rd_data_q;
        rd_err      = rd_err_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Testbench for reg_bank_reader: a Depth=4 instance for the main scenarios and
// a Depth=3 instance for out-of-range addressing. Expected responses are
// queued when a request is accepted and compared while the response is shown.
module tb_reg_bank_reader;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- Depth = 4 instance ----------------
    logic [1:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic       wr_en, rd_req, rd_ready, rd_valid, rd_err, rd_ack, dbg_state;

    reg_bank_reader #(.Size(8), .Depth(4), .AddrBits(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .rd_ack     (rd_ack),
        .dbg_state_o(dbg_state)
    );

    // ---------------- Depth = 3 instance ----------------
    logic [1:0] wr_addr3, rd_addr3;
    logic [7:0] wr_data3, rd_data3;
    logic       wr_en3, rd_req3, rd_ready3, rd_valid3, rd_err3, rd_ack3, dbg_state3;

    reg_bank_reader #(.Size(8), .Depth(3), .AddrBits(2)) dut3 (
        .clock      (clock),
        .reset      (reset),
        .wr_addr    (wr_addr3),
        .wr_data    (wr_data3),
        .wr_en      (wr_en3),
        .rd_req     (rd_req3),
        .rd_addr    (rd_addr3),
        .rd_ready   (rd_ready3),
        .rd_valid   (rd_valid3),
        .rd_data    (rd_data3),
        .rd_err     (rd_err3),
        .rd_ack     (rd_ack3),
        .dbg_state_o(dbg_state3)
    );

    // ---------------- scoreboard / model ----------------
    logic [8:0] exp_q[$];    // {err, data} for the Depth=4 instance
    logic [8:0] exp3_q[$];   // {err, data} for the Depth=3 instance
    logic [7:0] model[4];
    logic [7:0] model3[3];
    logic       m_valid;
    int         n_checks;
    int         n_fail;

    // One cycle on the Depth=4 instance. Called at a falling edge: drives the
    // inputs, checks the currently displayed outputs, updates the model for
    // the coming rising edge, then advances to the next falling edge.
    task automatic drive(input logic req, input logic [1:0] raddr, input logic ack,
                         input logic we, input logic [1:0] waddr, input logic [7:0] wdata);
        logic       exp_ready;
        logic       accept;
        logic [8:0] exp;
        rd_req  = req;
        rd_addr = raddr;
        rd_ack  = ack;
        wr_en   = we;
        wr_addr = waddr;
        wr_data = wdata;
        #1;
        exp_ready = !m_valid || ack;
        n_checks++;
        if (rd_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL rd_ready: got %b want %b", rd_ready, exp_ready);
        end
        n_checks++;
        if (rd_valid !== m_valid || dbg_state !== m_valid) begin
            n_fail++;
            $display("FAIL rd_valid: got %b (state %b) want %b", rd_valid, dbg_state, m_valid);
        end
        if (m_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: response shown with empty queue, got %h", {rd_err, rd_data});
            end else begin
                if ({rd_err, rd_data} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rd_resp: got err=%b data=%h want err=%b data=%h",
                             rd_err, rd_data, exp_q[0][8], exp_q[0][7:0]);
                end
                if (ack) void'(exp_q.pop_front());
            end
        end
        accept = req && exp_ready;
        if (accept) begin
            exp = {1'b0, model[raddr]};
`ifdef REG_BANK_READER_BYPASS_EN
            if (we && (waddr == raddr)) exp = {1'b0, wdata};
`endif
            exp_q.push_back(exp);
        end
        m_valid = accept || (m_valid && !ack);
        if (we) model[waddr] = wdata;
        @(negedge clock);
    endtask

    // Synchronous reset of both instances; checks the post-reset outputs.
    task automatic do_reset();
        reset   = 1'b1;
        rd_req  = 1'b0; rd_ack  = 1'b0; wr_en  = 1'b0;
        rd_addr = '0;   wr_addr = '0;   wr_data = '0;
        rd_req3 = 1'b0; rd_ack3 = 1'b0; wr_en3 = 1'b0;
        rd_addr3 = '0;  wr_addr3 = '0;  wr_data3 = '0;
        @(negedge clock);
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || rd_err !== 1'b0 || rd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h err=%b ready=%b want 0 00 0 1",
                     rd_valid, rd_data, rd_err, rd_ready);
        end
        n_checks++;
        if (rd_valid3 !== 1'b0 || rd_data3 !== 8'h00 || rd_err3 !== 1'b0 || rd_ready3 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs3: got valid=%b data=%h err=%b ready=%b want 0 00 0 1",
                     rd_valid3, rd_data3, rd_err3, rd_ready3);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        for (int i = 0; i < 3; i++) model3[i] = 8'h00;
        m_valid = 1'b0;
        exp_q.delete();
        exp3_q.delete();
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        // Every entry reads back zero.
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 1'b1, 1'b0, 2'd0, 8'h00);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic test_basic_read();
        logic [7:0] vals[4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 1'b0, 1'b1, 2'(i), vals[i]);
        drive(1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 8'h00);   // accept addr 2
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00);   // expect 33 now
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00);   // back to idle
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 1'b1, 1'b0, 2'd0, 8'h00);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic test_backpressure();
        drive(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 8'h00);   // accept addr 1 (22)
        for (int i = 0; i < 5; i++) begin
            // Write AA to the entry being held and push a competing request.
            drive(1'b1, 2'd3, 1'b0, (i == 0), 2'd1, 8'hAA);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00);   // ack, still 22
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00);
        drive(1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 8'h00);   // entry 1 is now AA
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic test_read_during_write();
        drive(1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 8'h5A);   // same-edge write + read
        drive(1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00);   // shows 11 or 5A, re-read
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00);   // 5A in both builds
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic test_reset_mid_response();
        drive(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 8'h00);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00);   // response pending
        do_reset();                                   // valid/data drop to 0
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 1'b1, 1'b0, 2'd0, 8'h00);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic test_out_of_range();
        logic [1:0] addrs[5];
        logic [8:0] exp;
        logic [1:0] a;
        addrs = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 4; i++) begin
            wr_en3   = 1'b1;
            wr_addr3 = 2'(i);
            wr_data3 = 8'(8'h01 + i) | ((i == 3) ? 8'hF0 : 8'h00);
            if (i < 3) model3[i] = wr_data3;
            @(negedge clock);
        end
        wr_en3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = addrs[i];
            rd_req3  = 1'b1;
            rd_addr3 = a;
            rd_ack3  = 1'b1;
            exp = (a < 2'd3) ? {1'b0, model3[a]} : 9'h100;
            exp3_q.push_back(exp);
            @(negedge clock);
            #1;
            n_checks++;
            if (rd_valid3 !== 1'b1 || rd_ready3 !== 1'b1) begin
                n_fail++;
                $display("FAIL oor_valid: got valid=%b ready=%b want 1 1", rd_valid3, rd_ready3);
            end
            n_checks++;
            if ({rd_err3, rd_data3} !== exp3_q[0]) begin
                n_fail++;
                $display("FAIL oor_resp addr %0d: got err=%b data=%h want err=%b data=%h",
                         a, rd_err3, rd_data3, exp3_q[0][8], exp3_q[0][7:0]);
            end
            void'(exp3_q.pop_front());
        end
        rd_req3 = 1'b0;
        @(negedge clock);
        #1;
        n_checks++;
        if (rd_valid3 !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_idle: got valid=%b want 0", rd_valid3);
        end
        rd_ack3 = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_valid  = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        test_reset();
        test_basic_read();
        test_back_to_back();
        test_backpressure();
        test_read_during_write();
        test_random();
        test_reset_mid_response();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
- Register bank of Depth entries, each Size bits wide.
- Written through a per-entry write-enable port with the same semantics as the plain register: sync reset to zero, load on write enable.
- Read through a request/response handshake, so a consumer can fetch any entry with back-pressure.
- Sits between configuration/status producers (writers) and a bus-side or controller-side reader.

Parameters:
- Size, 8, data width of each entry in bits.
- Depth, 4, number of entries; need not be a power of two.
- AddrBits, 2, width of wr_addr/rd_addr; must satisfy 2**AddrBits >= Depth.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- wr_addr  input  AddrBits  entry index to write.
- wr_data  input  Size  write data.
- wr_en  input  1  write strobe; entry wr_addr loads wr_data at the clock edge.
- rd_req  input  1  read request; accepted when rd_req && rd_ready.
- rd_addr  input  AddrBits  entry index to read; sampled at acceptance.
- rd_ready  output  1  combinational: !rd_valid || rd_ack.
- rd_valid  output  1  response valid; held until acknowledged.
- rd_data  output  Size  response data; stable while rd_valid && !rd_ack.
- rd_err  output  1  response flag: requested address >= Depth; qualified by rd_valid.
- rd_ack  input  1  consumer accepts the response this cycle.

Behaviour:
- Reset value of every output and state:
  - all entries 0; rd_valid 0; rd_data 0; rd_err 0.
  - rd_ready is 1 after reset, since rd_valid = 0.
- Reset asserted mid-response: rd_valid drops to 0 on that edge and the pending response is discarded.
- Write path:
  - wr_en with wr_addr < Depth: entry loads wr_data at the edge.
  - wr_en with wr_addr >= Depth: ignored, with no side effects.
  - Writes are never stalled by the read side.
- Read FSM states:
  - IDLE (rd_valid = 0).
  - RESP (rd_valid = 1).
- IDLE transitions:
  - rd_req = 1: capture, then RESP on the next edge.
  - Otherwise: stay in IDLE.
- RESP transitions:
  - rd_ack = 1 and rd_req = 0: go to IDLE.
  - rd_ack = 1 and rd_req = 1: back-to-back; capture the new response and stay in RESP.
  - rd_ack = 0: hold rd_data and rd_err unchanged, and ignore rd_req (rd_ready = 0).
- Capture at an accepting edge:
  - rd_data <= entry[rd_addr].
  - rd_err <= (rd_addr >= Depth).
  - When rd_addr >= Depth: rd_data <= 0 and rd_err <= 1.
- Latency: response is visible one cycle after acceptance.
- Sustained throughput is one read per cycle when rd_ack is held high.
- Read-during-write, same address, same edge: captured rd_data is the old entry value (feature off).
- A write to an entry whose value is being held in a pending response does not change rd_data; the response is a snapshot.
- No combinational path from rd_req or rd_addr to any output.
- rd_ready depends combinationally on rd_ack only.

Optional Feature:
- Macro: REG_BANK_READER_BYPASS_EN.
- Defined: on an accepting edge where wr_en && wr_addr == rd_addr && rd_addr < Depth, rd_data captures wr_data (write-to-read forwarding).
- Not defined: rd_data captures the pre-write entry value.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then write entries 0..3 = 8'h11, 8'h22, 8'h33, 8'h44; read addr 2 with rd_ack high -> rd_valid = 1 one cycle after request, rd_data = 8'h33, rd_err = 0.
- Back-pressure: request addr 1, hold rd_ack = 0 for 5 cycles, write 8'hAA to entry 1 meanwhile -> rd_data stays 8'h22, rd_ready = 0, and a new rd_req is ignored until ack.
- Back-to-back: rd_req high and rd_ack high for 4 cycles with addr 0, 1, 2, 3 -> rd_valid continuously 1, rd_data sequence 8'h11, 8'h22, 8'h33, 8'h44.
- Out of range, with Depth = 3 and AddrBits = 2: read addr 3 -> rd_err = 1, rd_data = 0; write to addr 3 changes no entry, checked by reading back 0..2.
- Read-during-write: same edge, wr_en addr 0 data 8'h5A and rd_req addr 0 (entry 0 was 8'h11) -> rd_data = 8'h11 without the macro, 8'h5A with it; a subsequent read returns 8'h5A in both builds.
- Reset mid-response: assert reset while rd_valid = 1 and rd_ack = 0 -> next cycle rd_valid = 0, rd_data = 0, all entries read back 0.
